// File: rtl/sha_nonce_scheduler_pkg.sv
// Shared constants and types for the SHA-256 nonce scheduler: IV, padding tails,
// FSM state encodings and the pass selector used by the block formatter.
package sha_nonce_scheduler_pkg;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Padding tails for an 80-byte header (second chunk) and a 32-byte digest.
  localparam logic [383:0] PAD_640 = {32'h80000000, 288'h0, 64'd640};
  localparam logic [255:0] PAD_256 = {32'h80000000, 160'h0, 64'd256};

  typedef logic [31:0] nonce_t;

  typedef logic [3:0] sched_state_e;
  localparam sched_state_e S_IDLE  = 4'd0;
  localparam sched_state_e S_M_LD  = 4'd1;
  localparam sched_state_e S_M_WT  = 4'd2;
  localparam sched_state_e S_P1_LD = 4'd3;
  localparam sched_state_e S_P1_WT = 4'd4;
  localparam sched_state_e S_P2_LD = 4'd5;
  localparam sched_state_e S_P2_WT = 4'd6;
  localparam sched_state_e S_CHK   = 4'd7;
  localparam sched_state_e S_DONE  = 4'd8;

  typedef enum logic [1:0] {
    PASS_M = 2'd0,
    PASS_1 = 2'd1,
    PASS_2 = 2'd2
  } pass_e;

endpackage

// File: rtl/sha_nonce_scheduler_if.sv
// Request/response bus between the nonce scheduler and the shared SHA-256 transform core.
interface sha_nonce_scheduler_if;
  logic [511:0] sha_block;
  logic [255:0] sha_state_in;
  logic         sha_load;
  logic [255:0] sha_hash;
  logic         sha_done;

  modport master (output sha_block, sha_state_in, sha_load, input sha_hash, sha_done);
  modport slave  (input sha_block, sha_state_in, sha_load, output sha_hash, sha_done);
endinterface

// File: rtl/sha_nonce_scheduler_block_formatter.sv
// Combinational mapping from the current pass to the 512-bit block and chaining state
// presented to the transform core.
module sha_block_formatter
  import sha_nonce_scheduler_pkg::*;
(
  input  pass_e         pass,
  input  logic [639:32] header,
  input  nonce_t        nonce,
  input  logic [255:0]  midstate,
  input  logic [255:0]  h1,
  output logic [511:0]  block,
  output logic [255:0]  state_in
);

  always_comb begin
    block    = '0;
    state_in = SHA256_IV;
    case (pass)
      PASS_M: block = header[639:128];
      PASS_1: begin
        block    = {header[127:32], nonce, PAD_640};
        state_in = midstate;
      end
      PASS_2: block = {h1, PAD_256};
      default: block = '0;
    endcase
  end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Drives one shared SHA-256 core through midstate, pass 1 and pass 2 for each nonce
// and reports the first nonce whose final digest does not exceed the target.
module sha_nonce_scheduler
  import sha_nonce_scheduler_pkg::*;
#(
  parameter int NONCE_W     = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [639:0]           header,
  input  logic [255:0]           target,
  input  logic [NONCE_W-1:0]     nonce_start,
  input  logic [31:0]            nonce_count,
  sha_nonce_scheduler_if.master  core,
  output logic                   busy,
  output logic                   found,
  output logic                   exhausted,
  output logic                   timeout_err,
  output logic [NONCE_W-1:0]     result_nonce,
  output logic [255:0]           result_hash
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_e         state_q, state_d;
  logic [639:32]        hdr_q, hdr_d;
  logic [255:0]         target_q, target_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [31:0]          remaining_q, remaining_d;
  logic [255:0]         midstate_q, midstate_d;
  logic [255:0]         h1_q, h1_d;
  logic [255:0]         digest_q, digest_d;
  logic [WD_W-1:0]      wdog_q, wdog_d, wdog_inc;
  logic                 found_q, found_d;
  logic                 exhausted_q, exhausted_d;
  logic                 timeout_q, timeout_d;
  logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;
  logic [255:0]         res_hash_q, res_hash_d;

  logic                 load, in_wait;
  pass_e                pass_sel;
  logic [511:0]         fmt_block;
  logic [255:0]         fmt_state;
  logic                 unused_hdr_nonce;

  // The header's own nonce field is replaced by the scheduled nonce.
  assign unused_hdr_nonce = ^header[31:0];

  assign load    = (state_q == S_M_LD) || (state_q == S_P1_LD) || (state_q == S_P2_LD);
  assign in_wait = (state_q == S_M_WT) || (state_q == S_P1_WT) || (state_q == S_P2_WT);
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    pass_sel = PASS_M;
    if (state_q == S_P1_LD) pass_sel = PASS_1;
    if (state_q == S_P2_LD) pass_sel = PASS_2;
  end

  sha_block_formatter u_fmt (
    .pass     (pass_sel),
    .header   (hdr_q),
    .nonce    (nonce_t'(nonce_q)),
    .midstate (midstate_q),
    .h1       (h1_q),
    .block    (fmt_block),
    .state_in (fmt_state)
  );

  // Block and state are only driven while a load is being requested.
  assign core.sha_load     = load;
  assign core.sha_block    = load ? fmt_block : '0;
  assign core.sha_state_in = load ? fmt_state : '0;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    target_d    = target_q;
    nonce_d     = nonce_q;
    remaining_d = remaining_q;
    midstate_d  = midstate_q;
    h1_d        = h1_q;
    digest_d    = digest_q;
    wdog_d      = wdog_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    timeout_d   = timeout_q;
    res_nonce_d = res_nonce_q;
    res_hash_d  = res_hash_q;
    wdog_inc    = wdog_q + WD_W'(1);

    if (abort) begin
      state_d     = S_IDLE;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      timeout_d   = 1'b0;
      res_nonce_d = '0;
      res_hash_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            hdr_d       = header[639:32];
            target_d    = target;
            nonce_d     = nonce_start;
            remaining_d = nonce_count;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
            if (nonce_count == 32'd0) begin
              exhausted_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_M_LD;
            end
          end
        end
        // The load cycle itself counts as the first watchdog cycle.
        S_M_LD:  begin state_d = S_M_WT;  wdog_d = WD_W'(1); end
        S_P1_LD: begin state_d = S_P1_WT; wdog_d = WD_W'(1); end
        S_P2_LD: begin state_d = S_P2_WT; wdog_d = WD_W'(1); end
        S_M_WT: if (core.sha_done) begin
          midstate_d = core.sha_hash;
          state_d    = S_P1_LD;
        end
        S_P1_WT: if (core.sha_done) begin
          h1_d    = core.sha_hash;
          state_d = S_P2_LD;
        end
        S_P2_WT: if (core.sha_done) begin
          digest_d = core.sha_hash;
          state_d  = S_CHK;
        end
        S_CHK: begin
          res_nonce_d = nonce_q;
          res_hash_d  = digest_q;
          if (digest_q <= target_q) begin
            found_d = 1'b1;
            state_d = S_DONE;
          end else if (remaining_q == 32'd1) begin
            exhausted_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            nonce_d     = nonce_q + NONCE_W'(1);
            remaining_d = remaining_q - 32'd1;
            state_d     = S_P1_LD;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (in_wait && !core.sha_done) begin
        wdog_d = wdog_inc;
        if (wdog_inc == WD_W'(TIMEOUT_CYC)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      remaining_q <= '0;
      midstate_q  <= '0;
      h1_q        <= '0;
      digest_q    <= '0;
      wdog_q      <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      timeout_q   <= 1'b0;
      res_nonce_q <= '0;
      res_hash_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      target_q    <= target_d;
      nonce_q     <= nonce_d;
      remaining_q <= remaining_d;
      midstate_q  <= midstate_d;
      h1_q        <= h1_d;
      digest_q    <= digest_d;
      wdog_q      <= wdog_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      timeout_q   <= timeout_d;
      res_nonce_q <= res_nonce_d;
      res_hash_q  <= res_hash_d;
    end
  end

  assign found        = found_q;
  assign exhausted    = exhausted_q;
  assign timeout_err  = timeout_q;
  assign result_nonce = res_nonce_q;
  assign result_hash  = res_hash_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Scoreboard bench: a SHA-256 core stub answers loads, job tasks queue expected
// results and a monitor checks each completion as the scheduler reports it.
module tb_sha_nonce_scheduler;
  import sha_nonce_scheduler_pkg::*;

  localparam int TMO = 256;
  localparam int LAT = 3;

  localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
  localparam logic [31:0]  GEN_NONCE  = 32'h1dac2b7c;
  localparam logic [255:0] GEN_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [639:0] header = '0;
  logic [255:0] target = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_count = '0;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;

  sha_nonce_scheduler_if bus ();

  sha_nonce_scheduler #(.NONCE_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .header(header), .target(target), .nonce_start(nonce_start), .nonce_count(nonce_count),
    .core(bus), .busy(busy), .found(found), .exhausted(exhausted), .timeout_err(timeout_err),
    .result_nonce(result_nonce), .result_hash(result_hash));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic         f, e, t, chk_res;
    logic [31:0]  n;
    logic [255:0] h;
    int           loads;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] p1_q[$];
  int n_vec = 0, n_miss = 0;
  int load_cnt = 0, load_cyc = 0, ev_cnt = 0, ev_cyc = 0;
  logic stub_en = 1'b1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] hdr, input logic [31:0] nonce);
    logic [255:0] mid, h1;
    mid = compress(SHA256_IV, hdr[639:128]);
    h1  = compress(mid, {hdr[127:32], nonce, 32'h80000000, 288'h0, 64'd640});
    return compress(SHA256_IV, {h1, 32'h80000000, 160'h0, 64'd256});
  endfunction

  // Core stub: counts every load, answers LAT cycles later unless disabled.
  initial begin
    int cnt;
    logic [255:0] hq;
    cnt = 0;
    hq = '0;
    bus.sha_done = 1'b0;
    bus.sha_hash = '0;
    forever begin
      @(negedge clk);
      bus.sha_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.sha_done = 1'b1;
          bus.sha_hash = hq;
        end
      end
      if (bus.sha_load === 1'b1) begin
        load_cnt++;
        load_cyc = cyc;
        if (bus.sha_state_in != SHA256_IV) p1_q.push_back(bus.sha_block[415:384]);
        if (stub_en) begin
          hq  = compress(bus.sha_state_in, bus.sha_block);
          cnt = LAT;
        end
      end
    end
  end

  // Monitor: a rising completion flag is one reported job result.
  initial begin
    logic prev, cur;
    exp_t x;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      cur = found | exhausted | timeout_err;
      if (cur && !prev) begin
        ev_cnt++;
        ev_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: got found=%0b exhausted=%0b timeout=%0b required no completion",
                   found, exhausted, timeout_err);
        end else begin
          x = exp_q.pop_front();
          check({x.name, "_found"},     256'(found),       256'(x.f));
          check({x.name, "_exhausted"}, 256'(exhausted),   256'(x.e));
          check({x.name, "_timeout"},   256'(timeout_err), 256'(x.t));
          check({x.name, "_loads"},     256'(load_cnt),    256'(x.loads));
          if (x.chk_res) begin
            check({x.name, "_nonce"}, 256'(result_nonce), 256'(x.n));
            check({x.name, "_hash"},  result_hash,        x.h);
          end
          $display("job %s: found=%0b exhausted=%0b timeout=%0b nonce=%h loads=%0d",
                   x.name, found, exhausted, timeout_err, result_nonce, load_cnt);
        end
      end
      prev = cur;
    end
  end

  task automatic wait_ev(input int ev0, input int budget, input string nm);
    for (int i = 0; i < budget && ev_cnt == ev0; i++) @(negedge clk);
    if (ev_cnt == ev0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_wait: got no completion within %0d cycles required one", nm, budget);
    end
  endtask

  task automatic issue(input string nm, input logic [639:0] hdr, input logic [255:0] tgt,
                       input logic [31:0] ns, input logic [31:0] nc, input logic ef, input logic ee,
                       input logic et, input logic cr, input logic [31:0] en, input logic [255:0] eh,
                       input int el);
    exp_t x;
    x.name = nm; x.f = ef; x.e = ee; x.t = et; x.chk_res = cr; x.n = en; x.h = eh; x.loads = el;
    exp_q.push_back(x);
    header = hdr; target = tgt; nonce_start = ns; nonce_count = nc;
    load_cnt = 0;
    p1_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_cleared(input string nm);
    check({nm, "_busy"},   256'(busy),             256'(0));
    check({nm, "_load"},   256'(bus.sha_load),     256'(0));
    check({nm, "_block"},  bus.sha_block[511:256], 256'(0));
    check({nm, "_state"},  bus.sha_state_in,       256'(0));
    check({nm, "_flags"},  256'({found, exhausted, timeout_err}), 256'(0));
    check({nm, "_rnonce"}, 256'(result_nonce),     256'(0));
    check({nm, "_rhash"},  result_hash,            256'(0));
  endtask

  initial begin
    int ev0, nl;
    logic [255:0] ones;
    ones = '1;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Empty range: DONE on the very next cycle, no core traffic.
    ev0 = ev_cnt;
    issue("count0", GEN_HDR, ones, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 0);
    check("count0_exh_next_cycle", 256'(exhausted), 256'(1));
    check("count0_busy", 256'(busy), 256'(0));
    wait_ev(ev0, 20, "count0");

    ev0 = ev_cnt;
    issue("hit_first", GEN_HDR, ones, 32'd5, 32'd10, 1'b1, 1'b0, 1'b0, 1'b1,
          32'd5, sha256d(GEN_HDR, 32'd5), 3);
    wait_ev(ev0, 500, "hit_first");

    ev0 = ev_cnt;
    issue("miss3", GEN_HDR, '0, 32'd0, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1,
          32'd2, sha256d(GEN_HDR, 32'd2), 7);
    wait_ev(ev0, 500, "miss3");

    ev0 = ev_cnt;
    issue("wrap", GEN_HDR, '0, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, 1'b0, 1'b1,
          32'd0, sha256d(GEN_HDR, 32'd0), 5);
    wait_ev(ev0, 500, "wrap");
    check("wrap_p1_count", 256'(p1_q.size()), 256'(2));
    if (p1_q.size() == 2) begin
      check("wrap_p1_first",  256'(p1_q[0]), 256'(32'hFFFFFFFF));
      check("wrap_p1_second", 256'(p1_q[1]), 256'(32'h0));
    end

    // Target set exactly to the genesis digest exercises the equality side of <=.
    ev0 = ev_cnt;
    issue("genesis", GEN_HDR, GEN_DIGEST, GEN_NONCE, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1,
          GEN_NONCE, GEN_DIGEST, 3);
    wait_ev(ev0, 500, "genesis");

    // Abort one cycle into pass-1 wait; the stub's answer then arrives late.
    header = GEN_HDR; target = '0; nonce_start = 32'd100; nonce_count = 32'd5;
    load_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nl = (bus.sha_load === 1'b1) ? 1 : 0;
    for (int i = 0; i < 50 && nl < 2; i++) begin
      @(negedge clk);
      if (bus.sha_load === 1'b1) nl++;
    end
    check("abort_reach_p1", 256'(nl), 256'(2));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_cleared("abort");
    repeat (8) @(negedge clk);
    check("abort_late_busy", 256'(busy), 256'(0));
    check("abort_late_loads", 256'(load_cnt), 256'(2));
    check("abort_late_flags", 256'({found, exhausted, timeout_err}), 256'(0));

    ev0 = ev_cnt;
    issue("restart", GEN_HDR, ones, 32'd7, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1,
          32'd7, sha256d(GEN_HDR, 32'd7), 3);
    wait_ev(ev0, 500, "restart");

    // Silent core: watchdog must fire TMO cycles after the single load.
    stub_en = 1'b0;
    ev0 = ev_cnt;
    issue("timeout", GEN_HDR, ones, 32'd1, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1);
    wait_ev(ev0, 2000, "timeout");
    check("timeout_latency", 256'(ev_cyc - load_cyc), 256'(TMO));
    check("timeout_busy", 256'(busy), 256'(0));

    repeat (4) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
